// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman key sequencer: state encoding
// and the default key width / watchdog limit.
package dh_pkg;

   localparam int DH_WIDTH   = 100;
   localparam int DH_TIMEOUT = 65535;

   typedef enum logic [2:0] {
      IDLE,
      PUB_START,
      PUB_WAIT,
      PEER_WAIT,
      SEC_START,
      SEC_WAIT,
      DONE,
      ERROR
   } dh_state_t;

endpackage

// File: rtl/dh_seq_watchdog.sv
// Wait-state watchdog for dh_key_sequencer; only instantiated when
// DH_TIMEOUT_EN is defined.
module dh_seq_watchdog #(
   parameter int LIMIT = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_eff;

   // The first cycle of a new state counts as cycle one, so the stale count
   // from the previous wait state is dropped combinationally.
   assign cnt_eff = clear ? '0 : cnt;
   assign expired = enable && (cnt_eff == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (enable)
         cnt <= cnt_eff + CW'(1);
      else
         cnt <= '0;
   end

endmodule

// File: rtl/dh_key_sequencer.sv
// Diffie-Hellman key-exchange sequencer driving an external mod-exp engine.
// Optional wait-state watchdog enabled by defining DH_TIMEOUT_EN.
module dh_key_sequencer
   import dh_pkg::*;
#(
   parameter int WIDTH          = DH_WIDTH,
   parameter int TIMEOUT_CYCLES = DH_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] prime,
   input  logic [WIDTH:0]   priv_key,
   input  logic [WIDTH-1:0] peer_pub,
   input  logic             peer_valid,
   output logic [WIDTH-1:0] pub_key,
   output logic             pub_valid,
   output logic [WIDTH-1:0] shared_key,
   output logic             shared_valid,
   output logic             busy,
   output logic             error,
   output logic             exp_start,
   output logic [WIDTH-1:0] exp_base,
   output logic [WIDTH:0]   exp_exp,
   output logic [WIDTH-1:0] exp_prime,
   input  logic [WIDTH-1:0] exp_result,
   input  logic             exp_done
);

   dh_state_t state;
   logic      wd_expired;

`ifdef DH_TIMEOUT_EN
   dh_state_t state_d1;
   logic      wd_clear;
   logic      wd_enable;

   always_ff @(posedge clk) begin
      if (rst)
         state_d1 <= IDLE;
      else
         state_d1 <= state;
   end

   assign wd_clear  = (state != state_d1);
   assign wd_enable = (state == PUB_WAIT) || (state == PEER_WAIT) || (state == SEC_WAIT);

   dh_seq_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear),
      .enable (wd_enable),
      .expired(wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   // The exp_* operand registers double as the latched copies of g, prime,
   // priv_key and peer_pub; they only change when a new exponentiation is
   // launched, which keeps them stable for the engine until exp_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         exp_start    <= 1'b0;
         exp_base     <= '0;
         exp_exp      <= '0;
         exp_prime    <= '0;
         pub_key      <= '0;
         pub_valid    <= 1'b0;
         shared_key   <= '0;
         shared_valid <= 1'b0;
         busy         <= 1'b0;
         error        <= 1'b0;
      end else begin
         exp_start <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  pub_valid    <= 1'b0;
                  shared_valid <= 1'b0;
                  error        <= 1'b0;
                  exp_base     <= g;
                  exp_exp      <= priv_key;
                  exp_prime    <= prime;
                  if (prime < WIDTH'(3)) begin
                     state <= ERROR;
                     error <= 1'b1;
                  end else begin
                     state     <= PUB_START;
                     exp_start <= 1'b1;
                     busy      <= 1'b1;
                  end
               end
            end
            PUB_START: state <= PUB_WAIT;
            PUB_WAIT: begin
               if (exp_done) begin
                  pub_key   <= exp_result;
                  pub_valid <= 1'b1;
                  state     <= PEER_WAIT;
               end else if (wd_expired) begin
                  state <= ERROR;
                  error <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            PEER_WAIT: begin
               if (peer_valid) begin
                  exp_base  <= peer_pub;
                  exp_start <= 1'b1;
                  state     <= SEC_START;
               end else if (wd_expired) begin
                  state <= ERROR;
                  error <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            SEC_START: state <= SEC_WAIT;
            SEC_WAIT: begin
               if (exp_done) begin
                  shared_key   <= exp_result;
                  shared_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= DONE;
               end else if (wd_expired) begin
                  state <= ERROR;
                  error <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/dh_key_sequencer.md
DH_KEY_SEQUENCER -- requirements
Module: dh_key_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 100, giving the base, prime and key width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the engine watchdog limit in clk cycles.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that launches a key exchange.
REQ-006 SHALL have ports g, input, WIDTH (generator) and prime, input, WIDTH (modulus).
REQ-007 SHALL have port priv_key, input, WIDTH+1, the local private exponent.
REQ-008 SHALL have ports peer_pub, input, WIDTH and peer_valid, input, 1 (level), carrying the remote public key.
REQ-009 SHALL have ports pub_key, output, WIDTH and pub_valid, output, 1, carrying the local public key.
REQ-010 SHALL have ports shared_key, output, WIDTH and shared_valid, output, 1, carrying the shared secret.
REQ-011 SHALL have ports busy, output, 1 and error, output, 1.
REQ-012 SHALL have engine-side outputs exp_start (1), exp_base (WIDTH), exp_exp (WIDTH+1) and exp_prime (WIDTH).
REQ-013 SHALL have engine-side inputs exp_result, input, WIDTH and exp_done, input, 1 (one-cycle pulse).

Function
REQ-014 SHALL implement the states IDLE, PUB_START, PUB_WAIT, PEER_WAIT, SEC_START, SEC_WAIT, DONE and ERROR.
REQ-015 IDLE: start=1 SHALL latch g, prime and priv_key; prime<3 SHALL go to ERROR, otherwise to PUB_START.
REQ-016 PUB_START SHALL drive exp_start=1 for exactly one cycle, with exp_base=g, exp_exp=priv_key and exp_prime=prime, then go to PUB_WAIT.
REQ-017 PUB_WAIT: exp_done=1 SHALL register exp_result into pub_key, set pub_valid=1 on the next cycle, and go to PEER_WAIT.
REQ-018 PEER_WAIT: peer_valid=1 SHALL latch peer_pub and go to SEC_START; a peer_valid already high on entry SHALL be taken that same cycle.
REQ-019 SEC_START SHALL pulse exp_start for one cycle, with exp_base=latched peer_pub, exp_exp=priv_key and exp_prime=prime, then go to SEC_WAIT.
REQ-020 SEC_WAIT: exp_done=1 SHALL register shared_key, set shared_valid=1 on the next cycle, and go to DONE.
REQ-021 DONE SHALL hold the key outputs; start=1 SHALL clear both valids and restart as from IDLE.
REQ-022 ERROR SHALL hold error=1; start=1 SHALL clear error and restart as from IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE, DONE and ERROR.
REQ-024 start while busy SHALL be ignored.
REQ-025 exp_done outside PUB_WAIT and SEC_WAIT SHALL be ignored.
REQ-026 exp_base, exp_exp and exp_prime SHALL stay stable from the exp_start cycle until exp_done.
REQ-027 SHALL perform no arithmetic on keys; a peer_pub >= prime SHALL be passed through unchanged.

Reset
REQ-028 rst=1 SHALL force IDLE, with all outputs 0 (exp_start, pub_valid, shared_valid, busy, error, pub_key, shared_key and exp_* buses), from any state, including mid-exponentiation.
REQ-029 An exp_done arriving after a reset SHALL be ignored.
REQ-030 The engine SHALL be reset externally from the same rst.

Configuration
REQ-031 With DH_TIMEOUT_EN defined, a cycle counter SHALL run in PUB_WAIT, SEC_WAIT and PEER_WAIT.
REQ-032 With DH_TIMEOUT_EN defined, the counter SHALL clear on every state entry, and reaching TIMEOUT_CYCLES without exp_done or peer_valid SHALL go to ERROR.
REQ-033 With DH_TIMEOUT_EN undefined, no counter SHALL exist, the wait states SHALL wait indefinitely, and error SHALL come only from REQ-015.

Structure
REQ-034 Package dh_pkg SHALL hold the state encoding and the WIDTH and TIMEOUT_CYCLES defaults.
REQ-035 The watchdog SHALL be sub-module dh_seq_watchdog (clear, enable, expired), instantiated only under DH_TIMEOUT_EN.

Verification
REQ-036 Against a behavioural mod-exp engine with 20-cycle latency, g=5, prime=23, priv_key=6, peer_pub=19 with peer_valid held high -> pub_key=8, then shared_key=2, with exactly two exp_start pulses.
REQ-037 The same case with peer_valid raised 50 cycles after pub_valid -> a wait in PEER_WAIT, then shared_key=2 with busy=1 throughout.
REQ-038 prime=2 -> error=1 one cycle after start, with no exp_start.
REQ-039 rst asserted in PUB_WAIT with exp_done arriving afterward -> all outputs 0, state IDLE, and no pub_valid.
REQ-040 Under DH_TIMEOUT_EN with TIMEOUT_CYCLES=100 and an engine that never completes -> error=1 at cycle 100 of PUB_WAIT.
REQ-041 A second start during SEC_WAIT -> ignored, with operands unchanged and shared_key=2.
